// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencing controller: one FSM walks each instruction
// through fetch/decode/execute/memory/writeback over a shared-memory datapath.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT  = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_SHI = 2'b11;

  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10;

endpackage

module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int opcode_width   = 6,
  parameter int function_width = 6,
  parameter int alu_con_width  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [opcode_width-1:0]   opcode,
  input  logic [function_width-1:0] funct,
  input  logic                      zero_flag,
  input  logic                      mem_ready,
  output logic                      mem_req,
  output logic                      iord,
  output logic                      mem_wr,
  output logic                      ir_wr,
  output logic                      pc_en,
  output logic [1:0]                pc_src,
  output logic                      alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic [alu_con_width-1:0]  alu_con,
  output logic                      reg_wr,
  output logic                      reg_dst,
  output logic                      mem_to_reg,
  output logic                      instr_done,
  output logic                      illegal_op,
  output logic [3:0]                state
);

  state_e state_q;
  state_e state_d;
  logic   [2:0] fn_alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    fn_alu = ALU_ADD;
    unique case (1'b1)
      (funct == FN_ADD): fn_alu = ALU_ADD;
      (funct == FN_SUB): fn_alu = ALU_SUB;
      (funct == FN_AND): fn_alu = ALU_AND;
      (funct == FN_OR):  fn_alu = ALU_OR;
      (funct == FN_SLT): fn_alu = ALU_SLT;
      default:           fn_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_con    = ALU_ADD;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_4;
        ir_wr     = mem_ready;
        pc_en     = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU computes the branch target ahead of knowing it is a branch
        alu_src_b = SRCB_SHI;
        unique case (1'b1)
          (opcode == OP_RTYPE): state_d = S_EXEC;
          (opcode == OP_LW),
          (opcode == OP_SW):    state_d = S_MEMADR;
          (opcode == OP_BEQ):   state_d = S_BRANCH;
          (opcode == OP_ADDI):  state_d = S_ADDIEX;
          (opcode == OP_J):     state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        mem_wr     = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_con   = fn_alu;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr     = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_con    = ALU_SUB;
        pc_src     = PC_BR;
        pc_en      = zero_flag;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_wr     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // No side effects may leak while reset is held
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_wr     = 1'b0;
      ir_wr      = 1'b0;
      pc_en      = 1'b0;
      reg_wr     = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized scoreboard bench for mips_multicycle_ctrl: per-cycle expected
// outputs are derived from per-instruction step lists and checked at negedge.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       iord;
    logic       mem_wr;
    logic       ir_wr;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       a;
    logic [1:0] b;
    logic [2:0] con;
    logic       reg_wr;
    logic       reg_dst;
    logic       m2r;
    logic       done;
    logic       ill;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, iord, mem_wr, ir_wr, pc_en;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a;
  logic [2:0] alu_con;
  logic       reg_wr, reg_dst, mem_to_reg, instr_done, illegal_op;
  logic [3:0] state;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  obs_t expq[$];
  obs_t mskq[$];

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_wr(mem_wr), .ir_wr(ir_wr),
    .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_con(alu_con), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  function automatic bit legal(logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  function automatic logic [2:0] alu_of(logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Output table: what each step of an instruction must show on the pins
  function automatic obs_t expect_out(int s, bit rdy, bit zf,
                                      logic [5:0] fn, bit ill);
    obs_t e;
    e = '0;
    e.st = 4'(s);
    e.con = 3'b010;
    case (s)
      0: begin e.mem_req = 1; e.b = 2'b01; e.ir_wr = rdy; e.pc_en = rdy; end
      1: begin e.b = 2'b11; e.ill = ill; e.done = ill; end
      2: begin e.a = 1; e.b = 2'b10; end
      3: begin e.mem_req = 1; e.iord = 1; end
      4: begin e.reg_wr = 1; e.m2r = 1; e.done = 1; end
      5: begin e.mem_req = 1; e.iord = 1; e.mem_wr = 1; e.done = rdy; end
      6: begin e.a = 1; e.con = alu_of(fn); end
      7: begin e.reg_wr = 1; e.reg_dst = 1; e.done = 1; end
      8: begin
        e.a = 1; e.con = 3'b110; e.pc_src = 2'b01;
        e.pc_en = zf; e.done = 1;
      end
      9: begin e.a = 1; e.b = 2'b10; end
      10: begin e.reg_wr = 1; e.done = 1; end
      11: begin e.pc_src = 2'b10; e.pc_en = 1; e.done = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t rst_exp();
    obs_t e;
    e = '0;
    e.b = 2'b01;
    e.con = 3'b010;
    return e;
  endfunction

  function automatic obs_t rst_mask();
    obs_t m;
    m = '0;
    m.st = 4'hf;
    m.mem_req = 1; m.mem_wr = 1; m.ir_wr = 1; m.pc_en = 1;
    m.reg_wr = 1; m.done = 1; m.ill = 1;
    return m;
  endfunction

  task automatic drive(bit rn, bit rdy, bit zf, logic [5:0] op,
                       logic [5:0] fn, obs_t e, obs_t m);
    @(posedge clk);
    #1;
    rst_n = rn;
    mem_ready = rdy;
    zero_flag = zf;
    opcode = op;
    funct = fn;
    expq.push_back(e);
    mskq.push_back(m);
  endtask

  // One instruction as a list of steps; abort_st injects reset there
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, bit zf,
                           int fstall, int mstall, int abort_st);
    int seq[$];
    bit rdy[$];
    bit ill;
    obs_t e;
    ill = !legal(op);
    for (int i = 0; i < fstall; i++) begin seq.push_back(0); rdy.push_back(0); end
    seq.push_back(0); rdy.push_back(1);
    seq.push_back(1); rdy.push_back(1'($urandom));
    if (op == 6'b000000) begin
      seq.push_back(6); rdy.push_back(1'($urandom));
      seq.push_back(7); rdy.push_back(1'($urandom));
    end else if (op == 6'b100011 || op == 6'b101011) begin
      int ms;
      ms = (op == 6'b100011) ? 3 : 5;
      seq.push_back(2); rdy.push_back(1'($urandom));
      for (int i = 0; i < mstall; i++) begin seq.push_back(ms); rdy.push_back(0); end
      seq.push_back(ms); rdy.push_back(1);
      if (op == 6'b100011) begin seq.push_back(4); rdy.push_back(1'($urandom)); end
    end else if (op == 6'b000100) begin
      seq.push_back(8); rdy.push_back(1'($urandom));
    end else if (op == 6'b001000) begin
      seq.push_back(9); rdy.push_back(1'($urandom));
      seq.push_back(10); rdy.push_back(1'($urandom));
    end else if (op == 6'b000010) begin
      seq.push_back(11); rdy.push_back(1'($urandom));
    end
    foreach (seq[k]) begin
      if (seq[k] == abort_st) begin
        drive(0, 1'($urandom), zf, op, fn, rst_exp(), rst_mask());
        return;
      end
      e = expect_out(seq[k], rdy[k], zf, fn, ill);
      drive(1, rdy[k], zf, op, fn, e, '1);
    end
  endtask

  always @(negedge clk) begin
    obs_t act, e, m;
    cyc++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      m = mskq.pop_front();
      act = '{st: state, mem_req: mem_req, iord: iord, mem_wr: mem_wr,
              ir_wr: ir_wr, pc_en: pc_en, pc_src: pc_src, a: alu_src_a,
              b: alu_src_b, con: alu_con, reg_wr: reg_wr,
              reg_dst: reg_dst, m2r: mem_to_reg, done: instr_done,
              ill: illegal_op};
      total++;
      if (((act ^ e) & m) != '0) begin
        bad++;
        $display("FAIL cyc%0d outputs act=%h exp=%h mask=%h (st act=%0d exp=%0d)",
                 cyc, act, e, m, act.st, e.st);
      end
    end
  end

  initial begin
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
    fns[3] = 6'b100101; fns[4] = 6'b101010;

    for (int i = 0; i < 3; i++)
      drive(0, 1, 0, 6'b0, 6'b0, rst_exp(), rst_mask());

    run_instr(6'b000000, 6'b100000, 0, 0, 0, -1);
    run_instr(6'b100011, 6'b0, 0, 0, 2, -1);
    run_instr(6'b000100, 6'b0, 1, 0, 0, -1);
    run_instr(6'b000100, 6'b0, 0, 0, 0, -1);
    run_instr(6'b101011, 6'b0, 0, 0, 0, -1);
    run_instr(6'b000010, 6'b0, 0, 0, 0, -1);
    run_instr(6'b111111, 6'b0, 0, 0, 0, -1);
    run_instr(6'b101011, 6'b0, 0, 1, 1, 5);
    run_instr(6'b000000, 6'b100010, 0, 0, 0, 7);
    run_instr(6'b001000, 6'b0, 0, 2, 0, -1);

    for (int n = 0; n < 300; n++) begin
      int k;
      k = $urandom_range(0, 6);
      op = (k == 6) ? 6'($urandom) : ops[k];
      k = $urandom_range(0, 5);
      fn = (k == 5) ? 6'($urandom) : fns[k];
      run_instr(op, fn, 1'($urandom),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                $urandom_range(0, 3),
                ($urandom_range(0, 19) == 0) ? $urandom_range(0, 11) : -1);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle sequencing controller for the MIPS core. It is the multi-cycle counterpart of the single-cycle control unit and drives a shared-memory datapath: one ALU, one memory port, and an instruction register. A registered FSM steps each instruction through fetch, decode, execute, memory and writeback, and stalls on a memory ready handshake. It supports the same instruction subset as the single-cycle core: R-type, lw, sw, beq, addi and j.

## Interface
- opcode_width, 6, opcode field width
- function_width, 6, funct field width
- alu_con_width, 3, ALU control width
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  6  opcode from the instruction register, stable from DECODE onward
- funct  in  6  funct field from the instruction register
- zero_flag  in  1  ALU zero output, combinational from the datapath
- mem_ready  in  1  memory has completed the current access this cycle
- mem_req  out  1  memory access request
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- mem_wr  out  1  memory write (valid only with mem_req)
- ir_wr  out  1  instruction register load
- pc_en  out  1  PC load
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate
- alu_con  out  3  ALU control: 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt
- reg_wr, reg_dst, mem_to_reg  out  1 each  register file control
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- state  out  4  current state, for debug

## Operation
- State register is 4 bits with the following encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11
  - Encodings 12–15 go to FETCH on the next clock.
- Output defaults: every output is 0 except alu_con = 010. Each state overrides only the outputs listed below.
- FETCH: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01.
  - ir_wr = pc_en = mem_ready.
  - If mem_ready = 1, go to DECODE; otherwise stay in FETCH.
- DECODE: alu_src_a = 0, alu_src_b = 11 (precomputes the branch target). Next state by opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - any other opcode → FETCH, with illegal_op = 1
- MEMADR: alu_src_a = 1, alu_src_b = 10. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req = 1, iord = 1. Go to MEMWB when mem_ready = 1; otherwise hold.
- MEMWB: reg_wr = 1, mem_to_reg = 1, reg_dst = 0. Next state FETCH.
- MEMWR: mem_req = 1, iord = 1, mem_wr = 1. Go to FETCH when mem_ready = 1; otherwise hold.
- EXEC: alu_src_a = 1, alu_src_b = 00. alu_con from funct:
  - 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111
  - any other funct → 010
  - Next state ALUWB.
- ALUWB: reg_wr = 1, reg_dst = 1. Next state FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_con = 110, pc_src = 01, pc_en = zero_flag. Next state FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10. Next state ADDIWB.
- ADDIWB: reg_wr = 1, reg_dst = 0. Next state FETCH.
- JUMP: pc_src = 10, pc_en = 1. Next state FETCH.
- instr_done = 1 in each of the following, then cleared:
  - MEMWB, ALUWB, BRANCH, ADDIWB, JUMP
  - MEMWR when mem_ready = 1
  - DECODE on an illegal opcode

## Timing
- The state register updates on the rising edge of clk.
- Outputs are decoded combinationally from the state. The exceptions depend on inputs within the cycle:
  - ir_wr and pc_en in FETCH (mem_ready)
  - pc_en in BRANCH (zero_flag)
  - instr_done in MEMWR (mem_ready)
  - illegal_op in DECODE (opcode)
- Reset: while rst_n = 0, state = FETCH and mem_req, mem_wr, ir_wr, pc_en, reg_wr, instr_done and illegal_op are all forced to 0. The first fetch request issues in the first cycle after rst_n rises.
- Reset asserted mid-instruction aborts it immediately. No partial writeback is allowed after rst_n falls.
- Latency with mem_ready tied to 1: j = 3, beq = 3, R-type = 4, addi = 4, sw = 4, lw = 5 cycles. Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- A memory request, once raised, stays asserted with a stable address select until mem_ready = 1.
- mem_ready arriving in a state that does not raise mem_req is ignored.

## Test plan
- Reset then R-type add (opcode 000000, funct 100000), mem_ready = 1 → states 0,1,6,7,0. alu_con = 010 in EXEC. reg_wr = reg_dst = 1 in ALUWB. instr_done pulses in cycle 4.
- lw with mem_ready low for 2 cycles in MEMRD → MEMRD held 3 cycles with mem_req = iord = 1. MEMWB asserts reg_wr = mem_to_reg = 1. Total 7 cycles.
- beq with zero_flag = 1, then zero_flag = 0 → pc_en = 1 with pc_src = 01 in the first case, pc_en = 0 in the second. alu_con = 110. Both take 3 cycles.
- sw and j back to back → MEMWR asserts mem_wr = 1 for exactly one cycle. JUMP asserts pc_en = 1 with pc_src = 10. mem_wr is never high outside MEMWR.
- Opcode 111111 → illegal_op and instr_done pulse in DECODE, next state FETCH. No reg_wr or mem_wr is asserted.
- rst_n dropped in MEMWR and in ALUWB → state = 0 immediately, with mem_wr = reg_wr = 0 in the same cycle. Normal fetch resumes after release.
